// File: rtl/csi_rx_raw10_unpacker.sv
// MIPI CSI-2 RAW10 unpacker: 32-bit payload words in, four 10-bit pixels per beat out,
// with per-line group counting and residual-byte error reporting.
module csi_rx_raw10_unpacker #(
    parameter int unsigned COUNT_WIDTH = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [31:0]            payload,
    input  logic                   payload_enable,
    input  logic                   payload_frame,
    output logic [39:0]            pixel_data,
    output logic                   pixel_enable,
    output logic                   line_valid,
    output logic                   line_end,
    output logic [COUNT_WIDTH-1:0] line_groups,
    output logic                   line_error
);

    localparam int unsigned BUF_BYTES   = 8;
    localparam int unsigned GROUP_BYTES = 5;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned PIX_W       = 10;

    // Residual bytes carried between words never exceed 4, so the stored count fits in 3 bits.
    logic [BUF_BYTES-1:0][7:0] buf_q;
    logic [2:0]                buf_count_q;
    logic [COUNT_WIDTH-1:0]    group_count_q;
    logic                      armed_q;
    logic                      frame_d_q;
    // Set once payload_frame has been observed low, so frame_d_q is a trustworthy edge
    // reference; a frame still high when reset is released is then not taken as a rising edge.
    logic                      low_seen_q;

    logic                      rise_c;
    logic                      fall_c;
    logic                      accept_c;
    logic                      extract_c;
    logic [BUF_BYTES-1:0][7:0] merged_c;
    logic [BUF_BYTES-1:0][7:0] shifted_c;
    logic [39:0]               pixels_c;

    assign rise_c    = low_seen_q && !frame_d_q && payload_frame;
    assign fall_c    = armed_q && frame_d_q && !payload_frame;
    assign accept_c  = (armed_q || rise_c) && payload_frame && payload_enable;
    assign extract_c = accept_c && (buf_count_q != 3'd0);

    // Append the incoming word after the residual bytes, then pick off the oldest group.
    always_comb begin
        merged_c  = buf_q;
        shifted_c = '0;
        pixels_c  = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            merged_c[buf_count_q + 3'(i)] = payload[8*i +: 8];
        end
        for (int j = 0; j < int'(BUF_BYTES - GROUP_BYTES); j++) begin
            shifted_c[j] = merged_c[j + int'(GROUP_BYTES)];
        end
        for (int p = 0; p < 4; p++) begin
            pixels_c[PIX_W*p +: PIX_W] = {merged_c[p], merged_c[4][2*p +: 2]};
        end
    end

    // Framing, buffering, group counting and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q         <= '0;
            buf_count_q   <= 3'd0;
            group_count_q <= '0;
            armed_q       <= 1'b0;
            frame_d_q     <= 1'b0;
            low_seen_q    <= 1'b0;
            pixel_data    <= '0;
            pixel_enable  <= 1'b0;
            line_valid    <= 1'b0;
            line_end      <= 1'b0;
            line_groups   <= '0;
            line_error    <= 1'b0;
        end else if (enable) begin
            pixel_enable <= extract_c;
            line_end     <= fall_c;
            line_valid   <= payload_frame && (armed_q || rise_c);
            frame_d_q    <= payload_frame;
            if (!payload_frame) begin
                low_seen_q <= 1'b1;
            end
            if (rise_c) begin
                armed_q <= 1'b1;
            end
            if (extract_c) begin
                pixel_data <= pixels_c;
            end
            // Clearing on the fall cycle leaves the buffer empty for a rise on the very next cycle.
            if (fall_c) begin
                line_groups   <= group_count_q;
                line_error    <= (buf_count_q != 3'd0);
                buf_count_q   <= 3'd0;
                group_count_q <= '0;
            end else if (accept_c) begin
                if (extract_c) begin
                    buf_q       <= shifted_c;
                    buf_count_q <= buf_count_q - 3'd1;
                    if (group_count_q != {COUNT_WIDTH{1'b1}}) begin
                        group_count_q <= group_count_q + COUNT_WIDTH'(1);
                    end
                end else begin
                    buf_q       <= merged_c;
                    buf_count_q <= 3'(WORD_BYTES);
                end
            end
        end
    end

endmodule

// File: doc/csi_rx_raw10_unpacker.md
Name: csi_rx_raw10_unpacker

Overview:
Sits directly downstream of the CSI-2 packet handler. It takes the 32-bit long-packet payload words and unpacks MIPI RAW10 byte groups into four 10-bit pixels per output beat. Each group is 5 bytes: 4 MSB bytes followed by 1 byte holding the LSB pairs. It also tracks line framing, reports the number of groups per line, and flags lines whose byte count is not a multiple of 5.

Parameters:
COUNT_WIDTH, 14, width of the per-line group counter and the line_groups output.

Ports:
clock  input  1  byte/word clock
reset  input  1  sync reset, active high
enable  input  1  clock enable; when low all registers hold
payload  input  32  payload word from packet handler; byte0 = [7:0] is first on the wire
payload_enable  input  1  payload word valid
payload_frame  input  1  high for the whole long-packet payload
pixel_data  output  40  4 pixels; pixel0 = [9:0], pixel1 = [19:10], pixel2 = [29:20], pixel3 = [39:30]
pixel_enable  output  1  pixel_data valid
line_valid  output  1  line framing aligned to the pixel outputs
line_end  output  1  one-cycle pulse at the end of each line
line_groups  output  COUNT_WIDTH  groups emitted in the last completed line
line_error  output  1  last line ended with 1-4 residual bytes

Behaviour:
- Reset values: all outputs 0. Internal state on reset:
  - byte buffer empty (count = 0)
  - group counter 0
  - armed = 0
  - frame_d (registered payload_frame) = 0
- All register updates are gated by enable. With enable low, nothing changes, including pulses: line_end holds its value.
- Arming:
  - After reset, words are ignored until a rising edge of payload_frame is seen (frame_d = 0, payload_frame = 1). This avoids unpacking a partial line if reset is released mid-packet.
  - armed sets on that edge and stays set until reset.
- Accept condition: armed && payload_frame && payload_enable. The word is accepted on the rising-edge cycle itself.
- Byte buffer:
  - 8-byte buffer with a count of 0..8.
  - An accepted word appends its 4 bytes in order [7:0], [15:8], [23:16], [31:24] after the existing count bytes.
- Group extraction:
  - If count+4 >= 5 after an append, the oldest 5 bytes b0..b4 are removed in the same cycle and the remainder shifts down. The count after the cycle is (count+4-5), which is always 0..4, so the buffer cannot overflow. At most one group is extracted per cycle.
  - Pixel i = {b_i, b4[2i+1:2i]}, for i = 0..3.
  - pixel_data is registered and pixel_enable is pulsed the cycle after the accepting cycle (latency 1).
  - Steady state: 4 groups per 5 input words.
  - The group counter increments per emitted group and saturates at all-ones.
- Line end:
  - Detected when frame_d = 1 && payload_frame = 0 (armed).
  - Next cycle: line_end = 1 for one cycle, line_groups <= counter (including a group emitted in that same cycle), line_error <= (residual count != 0).
  - Buffer and counter then clear. Residual bytes are discarded, never emitted.
  - line_error holds until the next line_end.
- line_valid is payload_frame delayed 1 cycle (registered) while armed; otherwise 0.
- Edge cases:
  - payload_enable while payload_frame = 0: ignored.
  - Words with payload_enable low inside the frame: no append, no output; the buffer holds.
  - Back-to-back lines: a rising edge in the cycle immediately after the falling edge is legal, and the buffer clear takes priority before the new append. The implementation must clear on the fall cycle, not one cycle later.
  - Reset mid-line: all state cleared, outputs to 0, armed = 0.

Test Plan:
- Single group: frame rises; words 0x04030201 then 0x000000E4 (enable both) → one pixel_enable beat with pixel_data = {10'h013, 10'h00E, 10'h009, 10'h004}, 1 cycle after the 2nd word. Buffer holds 3 bytes.
- Full line of 10 words (40 bytes) with incrementing bytes 0x00..0x27 → exactly 8 pixel beats, none in the cycle of the 1st word, each with the correct MSB/LSB mapping. line_end pulses once; line_groups = 8; line_error = 0.
- Short line of 3 words (12 bytes) → 2 beats, line_groups = 2, line_error = 1. Next correct line clears line_error at its line_end.
- Gaps: same 10-word line with payload_enable low every other cycle and enable toggled low mid-line → identical pixel sequence; no beats or pulses while enable = 0.
- Reset asserted with payload_frame = 1 mid-line, released with the frame still high → no pixel_enable until frame falls and rises again. The next line unpacks correctly from its first word.
- Back-to-back lines: frame low for exactly 1 cycle between two 5-word lines → two line_end pulses, line_groups = 4 each time, no bytes carried between lines.
